jamma_input_conditioner: RTL and testbench

- Front end for the multiplexed JAMMA control inputs.
- Drives JSELECT to time-share the 8-bit JJOY bus between player 1 and player 2.
- After each switch, waits a settle interval before sampling, so the external mux has stable outputs.
- Debounces every player/coin bit, merges the on-board JOYSTICK into player 1, and stretches coin pulses. Outputs feed the arcade core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs directly.

---
 rtl/jamma_input_conditioner_if.sv | 21 ++
 rtl/jamma_input_conditioner.sv | 121 ++++++++++++
 tb/tb_jamma_input_conditioner.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/jamma_input_conditioner_if.sv
// rtl/jamma_input_conditioner_if.sv - JAMMA input bus bundle between board pins and conditioner
interface jamma_input_conditioner_if;
    logic [7:0] JJOY;
    logic [5:0] JOYSTICK;
    logic [1:0] JCOIN;
    logic       JSELECT;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic [1:0] coin_n;
    logic       scan_done;

    modport master (
        output JJOY, JOYSTICK, JCOIN,
        input  JSELECT, joy1, joy2, coin_n, scan_done
    );

    modport slave (
        input  JJOY, JOYSTICK, JCOIN,
        output JSELECT, joy1, joy2, coin_n, scan_done
    );
endinterface

// File: rtl/jamma_input_conditioner.sv
// rtl/jamma_input_conditioner.sv - JAMMA mux scanner with per-bit debounce and coin pulse stretch
module jamma_input_conditioner #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DEB_SAMPLES   = 3,
    parameter int COIN_STRETCH  = 64
) (
    input logic CLK,
    input logic RESET,
    jamma_input_conditioner_if.slave bus
);
    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW  = (DEB_SAMPLES > 1)   ? $clog2(DEB_SAMPLES)   : 1;
    localparam int SCW = (COIN_STRETCH > 1)  ? $clog2(COIN_STRETCH)  : 1;
    localparam logic [SW-1:0]  SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  DEB_MAX     = CW'(DEB_SAMPLES - 1);
    localparam logic [SCW-1:0] STRETCH_LD  = SCW'(COIN_STRETCH - 1);
    localparam int NB = 18;

    typedef enum logic [1:0] {P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   settle_cnt;
    logic            settle_done;
    logic            jselect_q, jselect_nx;
    logic            scan_done_q;

    logic [NB-1:0]          smp, en, last, last_nx, deb, deb_nx;
    logic [NB-1:0][CW-1:0]  cnt, cnt_nx;
    logic [1:0][SCW-1:0]    stretch;
    logic [1:0]             coin_q;

    assign settle_done = (settle_cnt == SETTLE_MAX);

    always_comb begin
        state_nx = state;
        case (state)
            P1_SETTLE: if (settle_done) state_nx = P1_SAMPLE;
            P1_SAMPLE: state_nx = P2_SETTLE;
            P2_SETTLE: if (settle_done) state_nx = P2_SAMPLE;
            P2_SAMPLE: state_nx = P1_SETTLE;
            default:   state_nx = P1_SETTLE;
        endcase
        jselect_nx = (state_nx == P2_SETTLE) || (state_nx == P2_SAMPLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= P1_SETTLE;
            settle_cnt  <= '0;
            jselect_q   <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            jselect_q   <= jselect_nx;
            scan_done_q <= (state == P2_SAMPLE);
            if ((state == P1_SETTLE || state == P2_SETTLE) && !settle_done)
                settle_cnt <= settle_cnt + SW'(1);
            else
                settle_cnt <= '0;
        end
    end

    // Bit map: [7:0] player 1 (with on-board stick), [15:8] player 2, [17:16] coins.
    always_comb begin
        smp = {bus.JCOIN, bus.JJOY, bus.JJOY & {2'b11, bus.JOYSTICK}};
        en  = {{10{state == P2_SAMPLE}}, {8{state == P1_SAMPLE}}};
        last_nx = last;
        deb_nx  = deb;
        cnt_nx  = cnt;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) begin
                if (smp[i] == last[i]) begin
                    cnt_nx[i] = (cnt[i] == DEB_MAX) ? cnt[i] : cnt[i] + CW'(1);
                end else begin
                    cnt_nx[i]  = '0;
                    last_nx[i] = smp[i];
                end
                if (cnt_nx[i] == DEB_MAX)
                    deb_nx[i] = last_nx[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last <= '1;
            deb  <= '1;
            cnt  <= '0;
        end else begin
            last <= last_nx;
            deb  <= deb_nx;
            cnt  <= cnt_nx;
        end
    end

    // The stretch holds the output low for the counting cycles plus the load cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stretch <= '0;
            coin_q  <= 2'b11;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (deb[16+c] && !deb_nx[16+c]) begin
                    stretch[c] <= STRETCH_LD;
                    coin_q[c]  <= 1'b0;
                end else if (stretch[c] != '0) begin
                    stretch[c] <= stretch[c] - SCW'(1);
                    coin_q[c]  <= 1'b0;
                end else begin
                    coin_q[c]  <= deb_nx[16+c];
                end
            end
        end
    end

    assign bus.JSELECT   = jselect_q;
    assign bus.scan_done = scan_done_q;
    assign bus.joy1      = deb[7:0];
    assign bus.joy2      = deb[15:8];
    assign bus.coin_n    = coin_q;
endmodule

// File: tb/tb_jamma_input_conditioner.sv
// tb/tb_jamma_input_conditioner.sv - directed-vector bench for jamma_input_conditioner
module tb_jamma_input_conditioner;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    jamma_input_conditioner_if bus();

    jamma_input_conditioner #(
        .SETTLE_CYCLES(4),
        .DEB_SAMPLES(3),
        .COIN_STRETCH(64)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mux_en = 1'b0;
    bit coin_en = 1'b0;
    int p2_limit = 0;
    int coin_limit = 0;

    task automatic apply_stim();
        if (mux_en)
            bus.JJOY = bus.JSELECT ? ((cyc < p2_limit) ? 8'hFE : 8'hFF) : 8'hFF;
        if (coin_en)
            bus.JCOIN = (cyc < coin_limit) ? 2'b10 : 2'b11;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        apply_stim();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        mux_en = 1'b0;
        coin_en = 1'b0;
        bus.JJOY = 8'hFF;
        bus.JOYSTICK = 6'h3F;
        bus.JCOIN = 2'b11;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.JSELECT !== 1'b0) begin miscompares++; $display("FAIL reset_jselect got=%b exp=0", bus.JSELECT); end
        vectors++; if (bus.joy1 !== 8'hFF) begin miscompares++; $display("FAIL reset_joy1 got=%h exp=ff", bus.joy1); end
        vectors++; if (bus.joy2 !== 8'hFF) begin miscompares++; $display("FAIL reset_joy2 got=%h exp=ff", bus.joy2); end
        vectors++; if (bus.coin_n !== 2'b11) begin miscompares++; $display("FAIL reset_coin got=%b exp=11", bus.coin_n); end
        vectors++; if (bus.scan_done !== 1'b0) begin miscompares++; $display("FAIL reset_scan_done got=%b exp=0", bus.scan_done); end
    endtask

    task automatic test_scan_timing();
        logic [19:0] got, exp;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) step();
            got = {bus.JSELECT, bus.scan_done, bus.joy1, bus.joy2, bus.coin_n};
            exp = {((cyc % 10) >= 5) ? 1'b1 : 1'b0, (cyc > 0 && (cyc % 10) == 0) ? 1'b1 : 1'b0,
                   8'hFF, 8'hFF, 2'b11};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL scan_timing cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
    endtask

    task automatic test_p1_hold();
        logic [15:0] got, exp;
        do_reset();
        bus.JJOY = 8'hFE;
        for (int k = 0; k <= 35; k++) begin
            if (k > 0) step();
            got = {bus.joy1, bus.joy2};
            exp = {(cyc >= 25) ? 8'hFE : 8'hFF, (cyc >= 30) ? 8'hFE : 8'hFF};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL p1_hold cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] got, exp;
        do_reset();
        mux_en = 1'b1;
        p2_limit = 20;
        apply_stim();
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) step();
            got = {bus.joy1, bus.joy2};
            vectors++;
            if (got !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL glitch_2scan cyc=%0d got=%h exp=ffff", cyc, got);
            end
        end
        do_reset();
        mux_en = 1'b1;
        p2_limit = 30;
        apply_stim();
        for (int k = 0; k <= 62; k++) begin
            if (k > 0) step();
            got = {bus.joy1, bus.joy2};
            exp = {8'hFF, (cyc >= 30 && cyc < 60) ? 8'hFE : 8'hFF};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch_3scan cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
    endtask

    task automatic test_joystick();
        logic [15:0] got, exp;
        do_reset();
        bus.JOYSTICK = 6'b111011;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            got = {bus.joy1, bus.joy2};
            exp = {(cyc >= 25) ? 8'hFB : 8'hFF, 8'hFF};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL joystick_merge cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
        do_reset();
        bus.JOYSTICK = 6'h00;
        repeat (25) step();
        vectors++;
        if (bus.joy1 !== 8'hC0) begin
            miscompares++;
            $display("FAIL joystick_upper_bits got=%h exp=c0", bus.joy1);
        end
        vectors++;
        if (bus.joy2 !== 8'hFF) begin
            miscompares++;
            $display("FAIL joystick_p2_clean got=%h exp=ff", bus.joy2);
        end
    endtask

    task automatic test_coin();
        logic [1:0] exp;
        do_reset();
        coin_en = 1'b1;
        coin_limit = 30;
        apply_stim();
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) step();
            exp = (cyc >= 30 && cyc <= 93) ? 2'b10 : 2'b11;
            vectors++;
            if (bus.coin_n !== exp) begin
                miscompares++;
                $display("FAIL coin_stretch cyc=%0d got=%b exp=%b", cyc, bus.coin_n, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] got, exp;
        do_reset();
        mux_en = 1'b1;
        p2_limit = 1000;
        apply_stim();
        repeat (36) step();
        vectors++;
        if ({bus.JSELECT, bus.joy2} !== {1'b1, 8'hFE}) begin
            miscompares++;
            $display("FAIL reset_mid_pre got=%h exp=1fe", {bus.JSELECT, bus.joy2});
        end
        mux_en = 1'b0;
        bus.JJOY = 8'hFF;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc = 0;
        vectors++;
        if ({bus.JSELECT, bus.scan_done, bus.joy2} !== {1'b0, 1'b0, 8'hFF}) begin
            miscompares++;
            $display("FAIL reset_mid_post got=%h exp=0ff", {bus.JSELECT, bus.scan_done, bus.joy2});
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            got = {bus.JSELECT, bus.scan_done, bus.joy1, bus.joy2, bus.coin_n};
            exp = {((cyc % 10) >= 5) ? 1'b1 : 1'b0, ((cyc % 10) == 0) ? 1'b1 : 1'b0,
                   8'hFF, 8'hFF, 2'b11};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_p1_hold();
        test_glitch();
        test_joystick();
        test_coin();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
